vend_ctrl: RTL and testbench

Controller for the cola vending datapath. Accepts coin pulses in 0.5-yuan units and keeps a credit register. When credit reaches the price, it drives a dispenser through a req/ack handshake. It then returns change as a pulse train, and refunds on cancel or inactivity timeout.

---
 rtl/vend_ctrl_if.sv | 25 ++
 rtl/vend_ctrl.sv | 130 +++++++++++++
 tb/tb_vend_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_if.sv
// Signal bundle between the vending front panel/dispenser and vend_ctrl.
interface vend_ctrl_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic                pi_money_half;
  logic                pi_money_one;
  logic                pi_cancel;
  logic                pi_empty;
  logic                pi_disp_ack;
  logic                po_disp_req;
  logic                po_change;
  logic                po_coin_reject;
  logic [CREDIT_W-1:0] po_credit;
  logic                po_busy;

  modport master (
    output pi_money_half, pi_money_one, pi_cancel, pi_empty, pi_disp_ack,
    input  po_disp_req, po_change, po_coin_reject, po_credit, po_busy
  );

  modport slave (
    input  pi_money_half, pi_money_one, pi_cancel, pi_empty, pi_disp_ack,
    output po_disp_req, po_change, po_coin_reject, po_credit, po_busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Cola vending controller: credits coins, runs the dispense handshake and
// pays change/refunds as a pulse-then-gap train of 0.5-yuan units.
module vend_ctrl #(
  parameter int unsigned PRICE    = 6,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TO_W     = 10
) (
  input logic        clk,
  input logic        rst_n,
  vend_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COLLECT = 4'b0010,
    VEND    = 4'b0100,
    CHANGE  = 4'b1000
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit, credit_d, nc, v;
  logic [TO_W-1:0]     to_cnt, to_cnt_d;
  logic                gap, gap_d;
  logic                coin;
  logic                disp_req, disp_req_d;
  logic                change, change_d;
  logic                reject, reject_d;
  logic                busy, busy_d;

  // {one, half} read as a 2-bit number is exactly half + 2*one
  assign v    = CREDIT_W'({bus.pi_money_one, bus.pi_money_half});
  assign coin = bus.pi_money_one | bus.pi_money_half;
  assign nc   = credit + v;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (coin && !bus.pi_empty) state_d = (v >= PRICE_C) ? VEND : COLLECT;
      end
      COLLECT: begin
        // empty is treated like cancel so no vend is attempted on a dry dispenser
        if (bus.pi_cancel || bus.pi_empty)   state_d = CHANGE;
        else if (nc >= PRICE_C)              state_d = VEND;
        else if (!coin && to_cnt == TO_LAST) state_d = CHANGE;
      end
      VEND: begin
        if (bus.pi_disp_ack) state_d = (credit == PRICE_C) ? IDLE : CHANGE;
      end
      CHANGE: begin
        if (gap && credit == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d   = credit;
    to_cnt_d   = '0;
    gap_d      = 1'b0;
    change_d   = 1'b0;
    reject_d   = 1'b0;
    disp_req_d = (state_d == VEND);
    busy_d     = (state_d == VEND) || (state_d == CHANGE);
    case (state)
      IDLE: begin
        if (coin) begin
          if (bus.pi_empty) reject_d = 1'b1;
          else              credit_d = v;
        end
      end
      COLLECT: begin
        credit_d = nc;
        if (state_d == COLLECT && !coin) to_cnt_d = to_cnt + TO_W'(1);
      end
      VEND: begin
        reject_d = coin;
        if (bus.pi_disp_ack) credit_d = credit - PRICE_C;
      end
      CHANGE: begin
        reject_d = coin;
        // gap toggles every cycle; a unit is paid only on the non-gap cycle
        if (!gap) begin
          gap_d = 1'b1;
          if (credit != '0) begin
            change_d = 1'b1;
            credit_d = credit - CREDIT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit   <= '0;
      to_cnt   <= '0;
      gap      <= 1'b0;
      disp_req <= 1'b0;
      change   <= 1'b0;
      reject   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      credit   <= credit_d;
      to_cnt   <= to_cnt_d;
      gap      <= gap_d;
      disp_req <= disp_req_d;
      change   <= change_d;
      reject   <= reject_d;
      busy     <= busy_d;
    end
  end

  assign bus.po_credit      = credit;
  assign bus.po_disp_req    = disp_req;
  assign bus.po_change      = change;
  assign bus.po_coin_reject = reject;
  assign bus.po_busy        = busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed plus randomized bench for vend_ctrl against a transaction-level
// model that tracks credit and a queued refund schedule.
module tb_vend_ctrl;

  localparam int unsigned PRICE    = 6;
  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned TO_W     = 5;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_VEND    = 2;
  localparam int M_CHANGE  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

  vend_ctrl #(
    .PRICE   (PRICE),
    .CREDIT_W(CREDIT_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model
  int m_mode   = M_IDLE;
  int m_credit = 0;
  int m_idle   = 0;
  bit m_req, m_chg, m_rej, m_busy;
  bit refund_q[$];

  function automatic void start_refund();
    refund_q.delete();
    for (int i = 0; i < m_credit; i++) begin
      refund_q.push_back(1'b1);
      refund_q.push_back(1'b0);
    end
    m_mode = M_CHANGE;
  endfunction

  function automatic void model(bit h, bit o, bit c, bit e, bit a, bit rst);
    int  v;
    bit  b;
    v     = int'(h) + 2 * int'(o);
    m_chg = 1'b0;
    m_rej = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_credit = 0; m_idle = 0; refund_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (v > 0) begin
          if (e) m_rej = 1'b1;
          else begin
            m_credit = v;
            m_idle   = 0;
            m_mode   = (v >= PRICE) ? M_VEND : M_COLLECT;
          end
        end
        M_COLLECT: begin
          m_credit += v;
          m_idle = (v > 0) ? 0 : m_idle + 1;
          if (c || e)                start_refund();
          else if (m_credit >= PRICE) m_mode = M_VEND;
          else if (m_idle >= TIMEOUT) start_refund();
        end
        M_VEND: begin
          if (v > 0) m_rej = 1'b1;
          if (a) begin
            m_credit -= PRICE;
            if (m_credit > 0) start_refund();
            else              m_mode = M_IDLE;
          end
        end
        default: begin
          if (v > 0) m_rej = 1'b1;
          b = refund_q.pop_front();
          if (b) begin m_chg = 1'b1; m_credit -= 1; end
          if (refund_q.size() == 0) m_mode = M_IDLE;
        end
      endcase
    end
    m_req  = (m_mode == M_VEND);
    m_busy = (m_mode == M_VEND) || (m_mode == M_CHANGE);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge, compare.
  task automatic step(bit h, bit o, bit c, bit e, bit a);
    bus.pi_money_half = h;
    bus.pi_money_one  = o;
    bus.pi_cancel     = c;
    bus.pi_empty      = e;
    bus.pi_disp_ack   = a;
    model(h, o, c, e, a, !rst_n);
    @(posedge clk);
    #1;
    chk("credit", 32'(bus.po_credit),    32'(m_credit));
    chk("req",    32'(bus.po_disp_req),  32'(m_req));
    chk("change", 32'(bus.po_change),    32'(m_chg));
    chk("reject", 32'(bus.po_coin_reject), 32'(m_rej));
    chk("busy",   32'(bus.po_busy),      32'(m_busy));
    bus.pi_money_half = 1'b0;
    bus.pi_money_one  = 1'b0;
    bus.pi_cancel     = 1'b0;
    bus.pi_disp_ack   = 1'b0;
  endtask

  task automatic idle(int n, bit e = 1'b0);
    for (int i = 0; i < n; i++) step(0, 0, 0, e, 0);
  endtask

  initial begin
    bit h, o, c, a;
    bit e = 1'b0;
    int chg_cnt;

    bus.pi_money_half = 0; bus.pi_money_one = 0; bus.pi_cancel = 0;
    bus.pi_empty = 0; bus.pi_disp_ack = 0;

    // Reset
    rst_n = 1'b0;
    idle(2);
    chk("rst_credit", 32'(bus.po_credit), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Exact payment with six half coins
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      if (i < 5) begin
        chk("exact_credit", 32'(bus.po_credit), 32'(i + 1));
        idle(1);
      end
    end
    chk("exact_full_credit", 32'(bus.po_credit), 32'd6);
    chk("exact_req", 32'(bus.po_disp_req), 32'd1);
    idle(2);
    step(0, 0, 0, 0, 1);
    chk("exact_after_ack_credit", 32'(bus.po_credit), 32'd0);
    chk("exact_after_ack_busy", 32'(bus.po_busy), 32'd0);
    idle(2);

    // Simultaneous coins: 1, 4, 6
    step(1, 0, 0, 0, 0); idle(1);
    step(1, 1, 0, 0, 0);
    chk("simul_credit", 32'(bus.po_credit), 32'd4);
    idle(1);
    step(0, 1, 0, 0, 0); idle(2);
    step(0, 0, 0, 0, 1); idle(2);

    // Overpay to 7, one unit of change
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    chk("over_credit", 32'(bus.po_credit), 32'd7);
    idle(1);
    step(0, 0, 0, 0, 1);
    chk("over_rem", 32'(bus.po_credit), 32'd1);
    chk_cnt_reset: chg_cnt = 0;
    for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0, 0); chg_cnt += int'(bus.po_change); end
    chk("over_pulses", 32'(chg_cnt), 32'd1);

    // Cancel at credit 4
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chg_cnt = 0;
    for (int i = 0; i < 9; i++) begin step(0, 0, 0, 0, 0); chg_cnt += int'(bus.po_change); end
    chk("cancel_pulses", 32'(chg_cnt), 32'd4);

    // Inactivity timeout at credit 2
    step(0, 1, 0, 0, 0);
    idle(15);
    chk("timeout_not_yet", 32'(bus.po_busy), 32'd0);
    idle(1);
    chk("timeout_busy", 32'(bus.po_busy), 32'd1);
    idle(5);

    // Cancel with same-cycle one-yuan coin at credit 5
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("cancel_coin_credit", 32'(bus.po_credit), 32'd7);
    chk("cancel_coin_noreq", 32'(bus.po_disp_req), 32'd0);
    idle(15);

    // Rejects: empty in IDLE, coin in VEND, coin in CHANGE
    step(1, 0, 0, 1, 0);
    chk("empty_reject", 32'(bus.po_coin_reject), 32'd1);
    idle(1);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("vend_reject", 32'(bus.po_coin_reject), 32'd1);
    step(0, 0, 0, 0, 1); idle(1);
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    chk("change_reject", 32'(bus.po_coin_reject), 32'd1);
    idle(4);

    // Empty while collecting at credit 3
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chg_cnt = 0;
    for (int i = 0; i < 7; i++) begin step(0, 0, 0, 1, 0); chg_cnt += int'(bus.po_change); end
    chk("empty_pulses", 32'(chg_cnt), 32'd3);
    idle(1);

    // Reset mid-VEND
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); idle(1);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("rst_vend_req", 32'(bus.po_disp_req), 32'd0);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      h = ($urandom % 6) == 0;
      o = ($urandom % 6) == 0;
      c = ($urandom % 40) == 0;
      if (($urandom % 60) == 0) e = ~e;
      a = (m_mode == M_VEND) ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
      rst_n = (($urandom % 700) != 0);
      if (($urandom % 3) != 0) step(0, 0, 0, e, a);
      else                     step(h, o, c, e, a);
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
